// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: accepts a WIDTH-bit word on a valid/ready
// handshake and shifts it out LSB first with framing strobes. Define SER_PARITY_EN
// to append an even-parity bit to every frame.
module piso_serializer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] load_data,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             ser_out,
   output logic             ser_frame,
   output logic             ser_first,
   output logic             ser_last,
   output logic             busy
);

`ifdef SER_PARITY_EN
   localparam int F = WIDTH + 1;
`else
   localparam int F = WIDTH;
`endif
   localparam int             CW   = $clog2(WIDTH + 2);
   localparam logic [CW-1:0] LAST = CW'(F - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             last_bit, accept;
   logic             frame_d, ser_out_d, first_d, last_d;
`ifdef SER_PARITY_EN
   logic             par_q, par_d;
`endif

   always_comb begin
      last_bit   = (state_q == SHIFT) && (cnt_q == LAST);
      load_ready = !reset && ((state_q == IDLE) || last_bit);
      accept     = load_valid && load_ready;
   end

   always_comb begin
      // NOTE: every variable gets a default first, so no path can infer a latch.
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
`ifdef SER_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = SHIFT;
               shreg_d = load_data;
               cnt_d   = '0;
`ifdef SER_PARITY_EN
               par_d   = ^load_data;
`endif
            end
         end
         SHIFT: begin
            if (accept) begin
               // Back-to-back: the next frame starts right after this final bit.
               shreg_d = load_data;
               cnt_d   = '0;
`ifdef SER_PARITY_EN
               par_d   = ^load_data;
`endif
            end else if (last_bit) begin
               state_d = IDLE;
               shreg_d = '0;
               cnt_d   = '0;
            end else begin
               shreg_d = shreg_q >> 1;
               cnt_d   = cnt_q + CW'(1);
            end
         end
      endcase

      // Outputs are precomputed from next-state values so they leave flops.
      frame_d   = (state_d == SHIFT);
`ifdef SER_PARITY_EN
      ser_out_d = frame_d && ((cnt_d == CW'(WIDTH)) ? par_d : shreg_d[0]);
`else
      ser_out_d = frame_d && shreg_d[0];
`endif
      first_d   = frame_d && (cnt_d == '0);
      last_d    = frame_d && (cnt_d == LAST);
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      if (reset) begin
         // NOTE: the shift register is datapath, but it is cleared so an aborted
         // frame leaves no stale bits behind.
         state_q   <= IDLE;
         shreg_q   <= '0;
         cnt_q     <= '0;
         ser_out   <= 1'b0;
         ser_frame <= 1'b0;
         ser_first <= 1'b0;
         ser_last  <= 1'b0;
         busy      <= 1'b0;
`ifdef SER_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         cnt_q     <= cnt_d;
         ser_out   <= ser_out_d;
         ser_frame <= frame_d;
         ser_first <= first_d;
         ser_last  <= last_d;
         busy      <= frame_d;
`ifdef SER_PARITY_EN
         par_q     <= par_d;
`endif
      end
   end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: a WIDTH=8 instance driven from a vector table
// and frame sequences, plus a WIDTH=2 instance for the narrow-word corner.
module tb_piso_serializer;

`ifdef SER_PARITY_EN
   localparam int F  = 9;
   localparam int F2 = 3;
`else
   localparam int F  = 8;
   localparam int F2 = 2;
`endif
   localparam logic [5:0] IDLE_E = 6'b000001;

   logic       clk = 1'b0;
   logic       reset, load_valid, load_ready;
   logic [7:0] load_data;
   logic       ser_out, ser_frame, ser_first, ser_last, busy;

   logic       lv2, rdy2, o2, fr2, fi2, la2, bu2;
   logic [1:0] ld2;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       r;
      logic       v;
      logic [7:0] d;
      logic [5:0] e;   // {ser_out, ser_frame, ser_first, ser_last, busy, load_ready}
   } vec_t;
   vec_t tbl[$];

   always #5 clk = ~clk;

   piso_serializer #(.WIDTH(8)) dut (
      .clk(clk), .reset(reset), .load_data(load_data), .load_valid(load_valid),
      .load_ready(load_ready), .ser_out(ser_out), .ser_frame(ser_frame),
      .ser_first(ser_first), .ser_last(ser_last), .busy(busy)
   );

   piso_serializer #(.WIDTH(2)) dut_w2 (
      .clk(clk), .reset(reset), .load_data(ld2), .load_valid(lv2),
      .load_ready(rdy2), .ser_out(o2), .ser_frame(fr2),
      .ser_first(fi2), .ser_last(la2), .busy(bu2)
   );

   task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %b expected %b (out,frame,first,last,busy,ready)",
                  name, $time, act, exp);
      end
   endtask

   task automatic step(input string name, input logic r, input logic v,
                       input logic [7:0] d, input logic [5:0] exp);
      @(negedge clk);
      reset      = r;
      load_valid = v;
      load_data  = d;
      #1;
      check(name, {ser_out, ser_frame, ser_first, ser_last, busy, load_ready}, exp);
   endtask

   // Runs n cycles of a frame carrying w. load_valid is raised from cycle vk on
   // (vk<0: never) with data dm, and set to vl/dl on the final-bit cycle.
   task automatic frame(input string name, input logic [7:0] w, input int n,
                        input int vk, input logic [7:0] dm,
                        input logic vl, input logic [7:0] dl);
      logic [7:0] word;
      logic       e, last, v;
      word = w;
      for (int k = 0; k < n; k++) begin
         e    = (k < 8) ? word[k] : ^word;
         last = (k == F - 1);
         v    = last ? vl : (vk >= 0 && k >= vk);
         step(name, 1'b0, v, last ? dl : dm,
              {e, 1'b1, (k == 0), last, 1'b1, last});
      end
   endtask

   initial begin
      reset      = 1'b1;
      load_valid = 1'b0;
      load_data  = 8'h00;
      lv2        = 1'b0;
      ld2        = 2'b00;

      // Reset, then a single 8'hB5 frame (LSB first: 1,0,1,0,1,1,0,1).
      tbl.push_back('{1'b1, 1'b1, 8'hB5, 6'b000000});
      tbl.push_back('{1'b0, 1'b1, 8'hB5, 6'b000001});
      tbl.push_back('{1'b0, 1'b0, 8'h00, 6'b111010});
      tbl.push_back('{1'b0, 1'b0, 8'h00, 6'b010010});
      tbl.push_back('{1'b0, 1'b0, 8'h00, 6'b110010});
      tbl.push_back('{1'b0, 1'b0, 8'h00, 6'b010010});
      tbl.push_back('{1'b0, 1'b0, 8'h00, 6'b110010});
      tbl.push_back('{1'b0, 1'b0, 8'h00, 6'b110010});
      tbl.push_back('{1'b0, 1'b0, 8'h00, 6'b010010});
`ifdef SER_PARITY_EN
      tbl.push_back('{1'b0, 1'b0, 8'h00, 6'b110010});
      tbl.push_back('{1'b0, 1'b0, 8'h00, 6'b110111});
`else
      tbl.push_back('{1'b0, 1'b0, 8'h00, 6'b110111});
`endif
      tbl.push_back('{1'b0, 1'b0, 8'h00, IDLE_E});

      repeat (2) @(posedge clk);
      foreach (tbl[i]) step($sformatf("b5_vec%0d", i), tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].e);

      // Back-to-back 8'h01 then 8'h80 with load_valid held high.
      step("b2b_accept", 1'b0, 1'b1, 8'h01, IDLE_E);
      frame("b2b_a", 8'h01, F, 0, 8'h01, 1'b1, 8'h80);
      frame("b2b_b", 8'h80, F, 0, 8'h80, 1'b0, 8'h00);
      step("b2b_idle", 1'b0, 1'b0, 8'h00, IDLE_E);

      // 8'hFF offered from bit 3 of an 8'h00 frame; taken only on its final bit.
      step("mid_accept", 1'b0, 1'b1, 8'h00, IDLE_E);
      frame("mid_00", 8'h00, F, 3, 8'hFF, 1'b1, 8'hFF);
      frame("mid_ff", 8'hFF, F, -1, 8'h00, 1'b0, 8'h00);
      step("mid_idle", 1'b0, 1'b0, 8'h00, IDLE_E);

      // Reset during bit 4 of 8'hAA, with a word offered alongside the reset.
      step("rst_accept", 1'b0, 1'b1, 8'hAA, IDLE_E);
      frame("rst_aa", 8'hAA, 4, -1, 8'h00, 1'b0, 8'h00);
      step("rst_hit", 1'b1, 1'b1, 8'h55, 6'b010010);
      step("rst_after", 1'b0, 1'b1, 8'h0F, IDLE_E);
      frame("rst_0f", 8'h0F, F, -1, 8'h00, 1'b0, 8'h00);
      step("rst_idle", 1'b0, 1'b0, 8'h00, IDLE_E);

      // load_data changes right after the accept of 8'hC3.
      step("hold_accept", 1'b0, 1'b1, 8'hC3, IDLE_E);
      frame("hold_c3", 8'hC3, F, -1, 8'h00, 1'b0, 8'h00);
      step("hold_idle", 1'b0, 1'b0, 8'h00, IDLE_E);

      // WIDTH=2 instance, word 2'b10: stream 0,1 (then parity 1 if enabled).
      @(negedge clk);
      lv2 = 1'b1;
      ld2 = 2'b10;
      #1;
      check("w2_accept", {o2, fr2, fi2, la2, bu2, rdy2}, IDLE_E);
      @(negedge clk);
      lv2 = 1'b0;
      ld2 = 2'b00;
      #1;
      check("w2_bit0", {o2, fr2, fi2, la2, bu2, rdy2}, 6'b011010);
      @(negedge clk);
      #1;
      check("w2_bit1", {o2, fr2, fi2, la2, bu2, rdy2}, (F2 == 2) ? 6'b110111 : 6'b110010);
      if (F2 == 3) begin
         @(negedge clk);
         #1;
         check("w2_par", {o2, fr2, fi2, la2, bu2, rdy2}, 6'b110111);
      end
      @(negedge clk);
      #1;
      check("w2_idle", {o2, fr2, fi2, la2, bu2, rdy2}, IDLE_E);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
